// File: rtl/starflux_pkg.sv
// starflux_pkg: shared direction indices, screen size and move-FSM encodings
package starflux_pkg;
  localparam int DIR_RIGHT = 3;
  localparam int DIR_LEFT = 2;
  localparam int DIR_DOWN = 1;
  localparam int DIR_UP = 0;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SLOW = 2'd1;
  localparam logic [1:0] S_FAST = 2'd2;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: enable-gated prescaler, one-cycle tick every DIV enabled cycles
//   clock, reset (sync, active-high), enable (0 freezes count), tick (count==DIV-1)
module tick_divider #(
  parameter int DIV = 833333
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == W'(DIV - 1);
  always_ff @(posedge clock)
    if (reset) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/player_position_ctrl.sv
// player_position_ctrl: tick-rate 2-axis player position with bound saturation
//   clock, reset (sync, active-high), enable, right/left/down/up (held levels)
//   x_val/y_val registered coordinates, moved 1-cycle change pulse,
//   at_edge {right,left,down,up} bound reached (combinational from x_val/y_val)
//   PLAYER_POS_ACCEL_EN: adds IDLE/SLOW/FAST hold FSM doubling the step when held
module player_position_ctrl
  import starflux_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int X_MIN = 0,
  parameter int X_MAX = SCREEN_W - 1,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = SCREEN_H - 1,
  parameter int X_INIT = 80,
  parameter int Y_INIT = 100,
  parameter int TICK_DIV = 833333,
  parameter int STEP = 1,
  parameter int HOLD_TICKS = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  input  logic           right,
  input  logic           left,
  input  logic           down,
  input  logic           up,
  output logic [X_W-1:0] x_val,
  output logic [Y_W-1:0] y_val,
  output logic           moved,
  output logic [3:0]     at_edge
);
  if (TICK_DIV < 2 || STEP < 1 || HOLD_TICKS < 1 || X_MIN > X_INIT || X_INIT > X_MAX ||
      X_MAX >= 2 ** X_W || Y_MIN > Y_INIT || Y_INIT > Y_MAX || Y_MAX >= 2 ** Y_W) begin : g_bad
    $error("player_position_ctrl: invalid parameters");
  end
  // Opposing or absent presses hold the axis; the wide compare keeps pos+/-step from wrapping.
  function automatic logic [31:0] clamp_step(input logic [31:0] pos, input logic inc,
                                             input logic dec, input logic [31:0] st,
                                             input logic [31:0] lo, input logic [31:0] hi);
    clamp_step = (inc && !dec) ? ((pos + st > hi) ? hi : pos + st) :
                 (dec && !inc) ? ((pos < lo + st) ? lo : pos - st) : pos;
  endfunction
  logic tick;
  logic [31:0] st;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  tick_divider #(.DIV(TICK_DIV)) u_div (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );
`ifdef PLAYER_POS_ACCEL_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);
  logic [1:0] state;
  logic [HW-1:0] hold, hold_nxt;
  logic any_dir;
  assign any_dir = right | left | down | up;
  assign hold_nxt = (hold == HW'(HOLD_TICKS)) ? hold : hold + 1'b1;
  // The IDLE->SLOW tick counts as the first held tick toward HOLD_TICKS.
  always_ff @(posedge clock)
    if (reset) begin
      state <= S_IDLE;
      hold <= '0;
    end else if (tick) begin
      state <= !any_dir ? S_IDLE : (state == S_IDLE) ? S_SLOW :
               (hold_nxt == HW'(HOLD_TICKS)) ? S_FAST : state;
      hold <= any_dir ? hold_nxt : '0;
    end
  assign st = (state == S_FAST) ? 32'(2 * STEP) : 32'(STEP);
`else
  assign st = 32'(STEP);
`endif
  assign x_nxt = X_W'(clamp_step(32'(x_val), right, left, st, 32'(X_MIN), 32'(X_MAX)));
  assign y_nxt = Y_W'(clamp_step(32'(y_val), down, up, st, 32'(Y_MIN), 32'(Y_MAX)));
  always_ff @(posedge clock)
    if (reset) begin
      x_val <= X_W'(X_INIT);
      y_val <= Y_W'(Y_INIT);
      moved <= 1'b0;
    end else begin
      moved <= tick && (x_nxt != x_val || y_nxt != y_val);
      if (tick) begin
        x_val <= x_nxt;
        y_val <= y_nxt;
      end
    end
  assign at_edge[DIR_RIGHT] = x_val == X_W'(X_MAX);
  assign at_edge[DIR_LEFT] = x_val == X_W'(X_MIN);
  assign at_edge[DIR_DOWN] = y_val == Y_W'(Y_MAX);
  assign at_edge[DIR_UP] = y_val == Y_W'(Y_MIN);
endmodule

// File: tb/tb_player_position_ctrl.sv
// tb_player_position_ctrl: directed vector bench for player_position_ctrl
module tb_player_position_ctrl;
  logic clock = 1'b0, reset = 1'b0, enable = 1'b0;
  logic right = 1'b0, left = 1'b0, down = 1'b0, up = 1'b0;
  logic [7:0] x_val, x2;
  logic [6:0] y_val, y2;
  logic moved, mv2;
  logic [3:0] at_edge, ae2;
  int nvec = 0, nerr = 0;
  always #5 clock = ~clock;
  player_position_ctrl #(.TICK_DIV(4), .STEP(1), .HOLD_TICKS(3)) dut (
    .clock(clock), .reset(reset), .enable(enable), .right(right), .left(left),
    .down(down), .up(up), .x_val(x_val), .y_val(y_val), .moved(moved), .at_edge(at_edge)
  );
  player_position_ctrl #(.TICK_DIV(4), .STEP(1), .HOLD_TICKS(3), .X_INIT(158)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .right(right), .left(left),
    .down(down), .up(up), .x_val(x2), .y_val(y2), .moved(mv2), .at_edge(ae2)
  );
  typedef struct {
    logic en;
    logic [3:0] dir;
    int cyc;
    int x;
    int y;
    logic mv;
    logic [3:0] eg;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    {right, left, down, up} = 4'b0000;
    enable = 1'b1;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask
  initial begin
    int pulses;
    // cycle counts land each check 1 cycle after a tick edge (every 4th edge from reset)
    tbl[0] = '{1'b1, 4'b0000, 20, 80, 100, 1'b0, 4'b0000};
    tbl[1] = '{1'b1, 4'b1000, 4, 81, 100, 1'b1, 4'b0000};
    tbl[2] = '{1'b1, 4'b1000, 1, 81, 100, 1'b0, 4'b0000};
    tbl[3] = '{1'b1, 4'b1000, 3, 82, 100, 1'b1, 4'b0000};
    tbl[4] = '{1'b1, 4'b1000, 4, 83, 100, 1'b1, 4'b0000};
    tbl[5] = '{1'b1, 4'b0000, 4, 83, 100, 1'b0, 4'b0000};
    tbl[6] = '{1'b1, 4'b1101, 4, 83, 99, 1'b1, 4'b0000};
    tbl[7] = '{1'b1, 4'b1101, 4, 83, 98, 1'b1, 4'b0000};
    tbl[8] = '{1'b1, 4'b0001, 2, 83, 98, 1'b0, 4'b0000};
    tbl[9] = '{1'b0, 4'b0001, 10, 83, 98, 1'b0, 4'b0000};
    tbl[10] = '{1'b1, 4'b0001, 1, 83, 98, 1'b0, 4'b0000};
    tbl[11] = '{1'b1, 4'b0001, 1, 83, 97, 1'b1, 4'b0000};
    do_reset();
    chk("reset x", 32'(x_val), 80);
    chk("reset y", 32'(y_val), 100);
    chk("reset moved", 32'(moved), 0);
    chk("reset at_edge", 32'(at_edge), 0);
    for (int i = 0; i < 12; i++) begin
      enable = tbl[i].en;
      {right, left, down, up} = tbl[i].dir;
      step(tbl[i].cyc);
      chk($sformatf("v%0d x", i), 32'(x_val), 32'(tbl[i].x));
      chk($sformatf("v%0d y", i), 32'(y_val), 32'(tbl[i].y));
      chk($sformatf("v%0d moved", i), 32'(moved), 32'(tbl[i].mv));
      chk($sformatf("v%0d at_edge", i), 32'(at_edge), 32'(tbl[i].eg));
    end
    do_reset();
    right = 1'b1;
    pulses = 0;
    for (int t = 1; t <= 4; t++) begin
      for (int c = 0; c < 4; c++) begin
        step(1);
        pulses += int'(mv2);
      end
      chk($sformatf("edge x tick%0d", t), 32'(x2), 159);
    end
    chk("edge moved pulses", 32'(pulses), 1);
    chk("edge at_edge", 32'(ae2), 32'(4'b1000));
    do_reset();
    right = 1'b1;
    step(4);
    chk("pre-reset x", 32'(x_val), 81);
    step(3);
    reset = 1'b1;
    step(1);
    chk("mid reset x", 32'(x_val), 80);
    chk("mid reset y", 32'(y_val), 100);
    chk("mid reset moved", 32'(moved), 0);
    reset = 1'b0;
    step(3);
    chk("restart no tick yet", 32'(x_val), 80);
    step(1);
    chk("restart first tick x", 32'(x_val), 81);
    chk("restart first tick moved", 32'(moved), 1);
`ifdef PLAYER_POS_ACCEL_EN
    begin
      int exp_x[6] = '{81, 82, 83, 85, 87, 89};
      do_reset();
      right = 1'b1;
      for (int t = 0; t < 6; t++) begin
        step(4);
        chk($sformatf("accel tick%0d x", t), 32'(x_val), 32'(exp_x[t]));
      end
      right = 1'b0;
      step(4);
      chk("accel release x", 32'(x_val), 89);
      right = 1'b1;
      step(4);
      chk("accel after idle x", 32'(x_val), 90);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
